// File: rtl/remote_comm.sv
// remote_comm: 16-bit command sender (two 8N1 bytes, high byte first)
// plus an independent 8N1 response byte receiver.
module remote_comm #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_snt,
    output logic        TX,
    input  logic        RX,
    output logic [7:0]  resp,
    output logic        resp_rdy
);

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } ctl_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // control FSM
    ctl_state_t  r_state;
    ctl_state_t  w_state_nxt;
    logic        w_accept;
    logic        w_load;
    logic [7:0]  w_load_byte;
    logic        w_set_snt;
    logic [7:0]  r_low_byte;
    logic        r_cmd_snt;

    // transmitter
    logic        r_tx;
    logic        r_tx_busy;
    logic [7:0]  r_tx_shift;
    logic [3:0]  r_tx_bit;
    logic [11:0] r_tx_baud;
    logic        w_tx_done;

    // receiver
    logic        r_rx_meta;
    logic        r_rx_sync;
    logic        r_rx_prev;
    logic        w_rx_fall;
    rx_state_t   r_rx_state;
    rx_state_t   w_rx_state_nxt;
    logic [11:0] r_rx_baud;
    logic [2:0]  r_rx_bits;
    logic [7:0]  r_rx_shift;
    logic        w_rx_clr;
    logic        w_rx_start_ok;
    logic        w_rx_shift_en;
    logic        w_rx_done;
    logic [7:0]  r_resp;
    logic        r_resp_rdy;

    // last clock of the stop bit of the byte on the line
    assign w_tx_done = r_tx_busy
                    && (r_tx_baud == BAUD_LAST)
                    && (r_tx_bit == 4'd9);

    // control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // control next state; byte 2 loads on byte 1's last stop clock
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_load_byte = cmd[15:8];
        w_set_snt   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (snd_cmd) begin
                    w_accept    = 1'b1;
                    w_load      = 1'b1;
                    w_load_byte = cmd[15:8];
                    w_state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (w_tx_done) begin
                    w_load      = 1'b1;
                    w_load_byte = r_low_byte;
                    w_state_nxt = LOW;
                end
            end
            LOW: begin
                if (w_tx_done) begin
                    w_set_snt   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // low byte capture and sent flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_low_byte <= 8'h00;
            r_cmd_snt  <= 1'b0;
        end else if (w_accept) begin
            r_low_byte <= cmd[7:0];
            r_cmd_snt  <= 1'b0;
        end else if (w_set_snt) begin
            r_cmd_snt  <= 1'b1;
        end
    end

    // TX shifter: ones shifted in behind the data form the stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_shift <= 8'hFF;
            r_tx_bit   <= 4'd0;
            r_tx_baud  <= 12'd0;
        end else if (w_load) begin
            r_tx       <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_shift <= w_load_byte;
            r_tx_bit   <= 4'd0;
            r_tx_baud  <= 12'd0;
        end else if (r_tx_busy) begin
            if (r_tx_baud == BAUD_LAST) begin
                r_tx_baud <= 12'd0;
                if (r_tx_bit == 4'd9) begin
                    r_tx_busy <= 1'b0;
                    r_tx      <= 1'b1;
                end else begin
                    r_tx_bit   <= r_tx_bit + 4'd1;
                    r_tx       <= r_tx_shift[0];
                    r_tx_shift <= {1'b1, r_tx_shift[7:1]};
                end
            end else begin
                r_tx_baud <= r_tx_baud + 12'd1;
            end
        end
    end

    // RX synchronizer plus one history flop for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    // receiver state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_state_nxt;
        end
    end

    // receiver next state and sample strobes
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_clr       = 1'b0;
        w_rx_start_ok  = 1'b0;
        w_rx_shift_en  = 1'b0;
        w_rx_done      = 1'b0;
        unique case (r_rx_state)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_clr       = 1'b1;
                    w_rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (r_rx_baud == HALF_LAST) begin
                    w_rx_clr = 1'b1;
                    if (r_rx_sync) begin
                        w_rx_state_nxt = RX_IDLE;
                    end else begin
                        w_rx_start_ok  = 1'b1;
                        w_rx_state_nxt = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (r_rx_baud == BAUD_LAST) begin
                    w_rx_clr      = 1'b1;
                    w_rx_shift_en = 1'b1;
                    if (r_rx_bits == 3'd7) begin
                        w_rx_state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (r_rx_baud == BAUD_LAST) begin
                    w_rx_clr       = 1'b1;
                    w_rx_done      = 1'b1;
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            default: begin
                w_rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    // receiver baud/bit counters and data shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_baud  <= 12'd0;
            r_rx_bits  <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            if (w_rx_clr || (r_rx_state == RX_IDLE)) begin
                r_rx_baud <= 12'd0;
            end else begin
                r_rx_baud <= r_rx_baud + 12'd1;
            end
            if (w_rx_start_ok) begin
                r_rx_bits <= 3'd0;
            end else if (w_rx_shift_en) begin
                r_rx_bits <= r_rx_bits + 3'd1;
            end
            if (w_rx_shift_en) begin
                r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            end
        end
    end

    // response register; a delivered byte wins over any clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp     <= 8'h00;
            r_resp_rdy <= 1'b0;
        end else if (w_rx_done) begin
            r_resp     <= r_rx_shift;
            r_resp_rdy <= 1'b1;
        end else if (w_accept || w_rx_start_ok) begin
            r_resp_rdy <= 1'b0;
        end
    end

    assign TX       = r_tx;
    assign cmd_snt  = r_cmd_snt;
    assign resp     = r_resp;
    assign resp_rdy = r_resp_rdy;

endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: directed checks of remote_comm at BAUD_DIV=16
// (framing, back-to-back bytes, loopback, glitch reject, async reset).
module tb_remote_comm;

    logic        clk;
    logic        rst_n;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt;
    logic        TX;
    logic        RX;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        loop;
    logic        rx_drv;
    int          n_chk;
    int          n_err;
    int          snt_rise;

    assign RX = loop ? TX : rx_drv;

    remote_comm #(.BAUD_DIV(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (cmd),
        .snd_cmd  (snd_cmd),
        .cmd_snt  (cmd_snt),
        .TX       (TX),
        .RX       (RX),
        .resp     (resp),
        .resp_rdy (resp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial snt_rise = 0;
    always @(posedge cmd_snt) snt_rise = snt_rise + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // called at a negedge; returns at the negedge after the sampling edge
    task automatic send(input logic [15:0] c);
        cmd     = c;
        snd_cmd = 1'b1;
        @(posedge clk);
        #1 snd_cmd = 1'b0;
        @(negedge clk);
    endtask

    // from the first negedge of a frame, sample each bit mid-period
    task automatic rd_frame(output logic [7:0] d,
                            output logic s,
                            output logic p);
        repeat (8) @(negedge clk);
        s = TX;
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            d[i] = TX;
        end
        repeat (16) @(negedge clk);
        p = TX;
    endtask

    task automatic chk_xfer(input logic [7:0] hi, input logic [7:0] lo);
        logic [7:0] d;
        logic       s;
        logic       p;
        check("tx_start", TX, 1'b0);
        rd_frame(d, s, p);
        check("b1_start", s, 1'b0);
        check("b1_data", d, hi);
        check("b1_stop", p, 1'b1);
        repeat (7) @(negedge clk);
        check("snt_mid", cmd_snt, 1'b0);
        @(negedge clk);
        check("b2_start", TX, 1'b0);
        rd_frame(d, s, p);
        check("b2_start_bit", s, 1'b0);
        check("b2_data", d, lo);
        check("b2_stop", p, 1'b1);
        repeat (7) @(negedge clk);
        check("snt_319", cmd_snt, 1'b0);
        @(negedge clk);
        check("snt_320", cmd_snt, 1'b1);
        check("tx_idle", TX, 1'b1);
    endtask

    task automatic drive_rx_byte(input logic [7:0] b);
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (16) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic count_tx_low(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (TX == 1'b0) lows = lows + 1;
        end
    endtask

    initial begin
        int snap;
        int lows;
        n_chk   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        cmd     = 16'h0000;
        snd_cmd = 1'b0;
        loop    = 1'b0;
        rx_drv  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", TX, 1'b1);
        check("rst_snt", cmd_snt, 1'b0);
        check("rst_resp", resp, 8'h00);
        check("rst_rdy", resp_rdy, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // basic two-byte transfer
        send(16'hA5C3);
        chk_xfer(8'hA5, 8'hC3);
        repeat (5) @(negedge clk);
        check("snt_hold", cmd_snt, 1'b1);

        // loopback: set after byte 1, clear at byte 2 start, set again
        loop = 1'b1;
        send(16'h1234);
        for (int n = 1; n <= 320; n++) begin
            @(negedge clk);
            if (n == 154) check("lb_rdy154", resp_rdy, 1'b0);
            if (n == 155) check("lb_rdy155", resp_rdy, 1'b1);
            if (n == 155) check("lb_resp1", resp, 8'h12);
            if (n == 170) check("lb_rdy170", resp_rdy, 1'b1);
            if (n == 171) check("lb_rdy171", resp_rdy, 1'b0);
            if (n == 171) check("lb_resp_hold", resp, 8'h12);
            if (n == 314) check("lb_rdy314", resp_rdy, 1'b0);
            if (n == 315) check("lb_rdy315", resp_rdy, 1'b1);
            if (n == 315) check("lb_resp2", resp, 8'h34);
            if (n == 320) check("lb_snt", cmd_snt, 1'b1);
        end
        repeat (4) @(negedge clk);
        loop = 1'b0;
        repeat (4) @(negedge clk);

        // re-pulse with a new cmd mid-transfer is ignored
        snap = snt_rise;
        send(16'h0F0F);
        fork
            chk_xfer(8'h0F, 8'h0F);
            begin
                repeat (100) @(negedge clk);
                cmd     = 16'hFFFF;
                snd_cmd = 1'b1;
                @(negedge clk);
                snd_cmd = 1'b0;
            end
        join
        count_tx_low(200, lows);
        check("ign_no_extra", lows, 0);
        check("ign_snt_once", snt_rise - snap, 1);

        // external frame, then snd_cmd clears resp_rdy only
        drive_rx_byte(8'h5A);
        repeat (4) @(negedge clk);
        check("ext_resp", resp, 8'h5A);
        check("ext_rdy", resp_rdy, 1'b1);
        send(16'h0000);
        check("ext_rdy_clr", resp_rdy, 1'b0);
        check("ext_resp_keep", resp, 8'h5A);
        chk_xfer(8'h00, 8'h00);

        // 4-clock glitch rejected; receiver idle in time for a new frame
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (7) @(negedge clk);
        check("gl_rdy", resp_rdy, 1'b0);
        check("gl_resp", resp, 8'h5A);
        drive_rx_byte(8'hC6);
        repeat (4) @(negedge clk);
        check("gl_next_resp", resp, 8'hC6);
        check("gl_next_rdy", resp_rdy, 1'b1);

        // asynchronous reset mid-transfer
        send(16'h3C81);
        repeat (150) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_tx", TX, 1'b1);
        check("ar_snt", cmd_snt, 1'b0);
        check("ar_resp", resp, 8'h00);
        check("ar_rdy", resp_rdy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_tx_low(400, lows);
        check("ar_tx_quiet", lows, 0);
        check("ar_snt_quiet", cmd_snt, 1'b0);
        check("ar_rdy_quiet", resp_rdy, 1'b0);
        send(16'h3C81);
        chk_xfer(8'h3C, 8'h81);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
